// File: rtl/sample_packer_if.sv
// Handshake bundle for sample_packer: stereo sample strobe in, packed 64-bit words out.
// The ovf_count signal exists only when SAMPLE_PACKER_OVF_CNT_EN is defined.
interface sample_packer_if #(
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned LW = $clog2(DEPTH) + 1;

    logic          sample_valid;
    logic [23:0]   sample_l;
    logic [23:0]   sample_r;
    logic          recording;
    logic          get_data;
    logic [63:0]   data_out;
    logic          data_ready;
    logic [LW-1:0] fill_level;
    logic          overflow;
`ifdef SAMPLE_PACKER_OVF_CNT_EN
    logic [15:0]   ovf_count;

    modport master (
        output sample_valid, sample_l, sample_r, recording, get_data,
        input  data_out, data_ready, fill_level, overflow, ovf_count
    );
    modport slave (
        input  sample_valid, sample_l, sample_r, recording, get_data,
        output data_out, data_ready, fill_level, overflow, ovf_count
    );
`else
    modport master (
        output sample_valid, sample_l, sample_r, recording, get_data,
        input  data_out, data_ready, fill_level, overflow
    );
    modport slave (
        input  sample_valid, sample_l, sample_r, recording, get_data,
        output data_out, data_ready, fill_level, overflow
    );
`endif
endinterface

// File: rtl/sample_packer.sv
// sample_packer: packs 24-bit stereo samples into {PAD, L, R} words and buffers them in a
// first-word-fall-through FIFO with a registered head word.
// Optional feature: define SAMPLE_PACKER_OVF_CNT_EN to add a saturating dropped-sample counter.
module sample_packer #(
    parameter int unsigned DEPTH = 8,
    parameter logic [15:0] PAD   = 16'h0000
) (
    input logic            clk,
    input logic            rst,
    sample_packer_if.slave bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    typedef enum logic [1:0] {StIdle, StCapture, StDrain} state_e;

    state_e        r_state;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_fill_level;
    logic          r_data_ready;
    logic [63:0]   r_data_out;
    logic          r_overflow;
    logic [63:0]   r_mem [DEPTH];

    logic          w_full;
    logic          w_cap;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic          w_clr;
    logic [63:0]   w_wdata;
    logic [PW-1:0] w_wr_nxt;
    logic [PW-1:0] w_rd_nxt;

    // Same low bits with differing MSB means the writer has lapped the reader.
    assign w_full   = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    // Capture only while still recording: a strobe in the CAPTURE->DRAIN cycle is dropped.
    assign w_cap    = (r_state == StCapture) && bus.recording && bus.sample_valid;
    assign w_pop    = bus.get_data && r_data_ready;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts the write.
    assign w_push   = w_cap && (!w_full || w_pop);
    assign w_drop   = w_cap && w_full && !w_pop;
    assign w_clr    = (r_state == StIdle) && bus.recording;
    assign w_wdata  = {PAD, bus.sample_l, bus.sample_r};
    assign w_wr_nxt = r_wr_ptr + {{AW{1'b0}}, w_push};
    assign w_rd_nxt = r_rd_ptr + {{AW{1'b0}}, w_pop};

    // Control FSM: IDLE -> CAPTURE on recording, CAPTURE -> DRAIN when recording drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            case (r_state)
                StIdle:    if (bus.recording) r_state <= StCapture;
                StCapture: if (!bus.recording) r_state <= StDrain;
                StDrain: begin
                    if (bus.recording) begin
                        r_state <= StCapture;
                    end else if (r_fill_level == '0) begin
                        r_state <= StIdle;
                    end
                end
                default:   r_state <= StIdle;
            endcase
        end
    end

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= w_wdata;
    end

    // Pointers, fill level and the registered head word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_fill_level <= '0;
            r_data_ready <= 1'b0;
            r_data_out   <= '0;
        end else begin
            r_wr_ptr     <= w_wr_nxt;
            r_rd_ptr     <= w_rd_nxt;
            r_fill_level <= w_wr_nxt - w_rd_nxt;
            r_data_ready <= (w_wr_nxt != w_rd_nxt);
            // Next head is the word being written now if it lands at the new read slot.
            if (w_wr_nxt != w_rd_nxt) begin
                if (w_rd_nxt == r_wr_ptr) begin
                    r_data_out <= w_wdata;
                end else begin
                    r_data_out <= r_mem[w_rd_nxt[AW-1:0]];
                end
            end
        end
    end

    // Sticky overflow flag, cleared when a fresh recording starts from IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overflow <= 1'b0;
        end else if (w_clr) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef SAMPLE_PACKER_OVF_CNT_EN
    logic [15:0] r_ovf_count;

    // Saturating count of dropped samples.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf_count <= '0;
        end else if (w_clr) begin
            r_ovf_count <= '0;
        end else if (w_drop && (r_ovf_count != 16'hFFFF)) begin
            r_ovf_count <= r_ovf_count + 16'd1;
        end
    end

    assign bus.ovf_count = r_ovf_count;
`endif

    assign bus.data_out   = r_data_out;
    assign bus.data_ready = r_data_ready;
    assign bus.fill_level = r_fill_level;
    assign bus.overflow   = r_overflow;
endmodule

// File: tb/tb_sample_packer.sv
// Directed self-checking bench for sample_packer (DEPTH=8, PAD=0).
module tb_sample_packer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    sample_packer_if #(.DEPTH(8)) bus ();

    sample_packer #(.DEPTH(8), .PAD(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] wd(input logic [23:0] l, input logic [23:0] r);
        return {16'h0000, l, r};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r);
        bus.sample_valid = 1'b1;
        bus.sample_l     = l;
        bus.sample_r     = r;
        step();
        bus.sample_valid = 1'b0;
    endtask

    task automatic pop();
        bus.get_data = 1'b1;
        step();
        bus.get_data = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (bus.data_ready !== 1'b0) begin n_err++;
            $display("FAIL rst_ready: got %b want 0", bus.data_ready); end
        n_cmp++; if (bus.fill_level !== 4'd0) begin n_err++;
            $display("FAIL rst_fill: got %0d want 0", bus.fill_level); end
        n_cmp++; if (bus.data_out !== 64'h0) begin n_err++;
            $display("FAIL rst_data: got %h want 0", bus.data_out); end
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++;
            $display("FAIL rst_ovf: got %b want 0", bus.overflow); end
`ifdef SAMPLE_PACKER_OVF_CNT_EN
        n_cmp++; if (bus.ovf_count !== 16'd0) begin n_err++;
            $display("FAIL rst_ovfcnt: got %0d want 0", bus.ovf_count); end
`endif
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic();
        bus.recording = 1'b1;
        step();
        push(24'hABCDEF, 24'h123456);
        n_cmp++; if (bus.data_ready !== 1'b1) begin n_err++;
            $display("FAIL basic_ready: got %b want 1", bus.data_ready); end
        n_cmp++; if (bus.data_out !== 64'h0000_ABCDEF_123456) begin n_err++;
            $display("FAIL basic_data: got %h want 0000abcdef123456", bus.data_out); end
        n_cmp++; if (bus.fill_level !== 4'd1) begin n_err++;
            $display("FAIL basic_fill: got %0d want 1", bus.fill_level); end
        pop();
        n_cmp++; if (bus.data_ready !== 1'b0 || bus.fill_level !== 4'd0) begin n_err++;
            $display("FAIL basic_pop: got ready=%b fill=%0d want 0/0", bus.data_ready,
                     bus.fill_level); end
        n_cmp++; if (bus.data_out !== 64'h0000_ABCDEF_123456) begin n_err++;
            $display("FAIL basic_hold: got %h want 0000abcdef123456", bus.data_out); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 10; i++) push(24'h100000 + 24'(i), 24'h200000 + 24'(i));
        step();
        n_cmp++; if (bus.fill_level !== 4'd8) begin n_err++;
            $display("FAIL ovf_fill: got %0d want 8", bus.fill_level); end
        n_cmp++; if (bus.overflow !== 1'b1) begin n_err++;
            $display("FAIL ovf_flag: got %b want 1", bus.overflow); end
`ifdef SAMPLE_PACKER_OVF_CNT_EN
        n_cmp++; if (bus.ovf_count !== 16'd2) begin n_err++;
            $display("FAIL ovf_count: got %0d want 2", bus.ovf_count); end
`endif
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (bus.data_out !== wd(24'h100000 + 24'(i), 24'h200000 + 24'(i))) begin n_err++;
                $display("FAIL ovf_order[%0d]: got %h want %h", i, bus.data_out,
                         wd(24'h100000 + 24'(i), 24'h200000 + 24'(i))); end
            pop();
        end
        n_cmp++; if (bus.data_ready !== 1'b0 || bus.overflow !== 1'b1) begin n_err++;
            $display("FAIL ovf_end: got ready=%b ovf=%b want 0/1", bus.data_ready,
                     bus.overflow); end
    endtask

    task automatic test_full_simul();
        bus.recording = 1'b0;
        step();
        step();
        bus.recording = 1'b1;
        step();
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++;
            $display("FAIL full_clr: got %b want 0", bus.overflow); end
        for (int i = 0; i < 8; i++) push(24'h300000 + 24'(i), 24'h400000 + 24'(i));
        n_cmp++; if (bus.fill_level !== 4'd8) begin n_err++;
            $display("FAIL full_fill: got %0d want 8", bus.fill_level); end
        bus.get_data = 1'b1;
        push(24'hFACADE, 24'hBEEF01);
        bus.get_data = 1'b0;
        step();
        n_cmp++; if (bus.fill_level !== 4'd8 || bus.overflow !== 1'b0) begin n_err++;
            $display("FAIL full_simul: got fill=%0d ovf=%b want 8/0", bus.fill_level,
                     bus.overflow); end
        for (int i = 1; i < 8; i++) begin
            n_cmp++;
            if (bus.data_out !== wd(24'h300000 + 24'(i), 24'h400000 + 24'(i))) begin n_err++;
                $display("FAIL full_order[%0d]: got %h want %h", i, bus.data_out,
                         wd(24'h300000 + 24'(i), 24'h400000 + 24'(i))); end
            pop();
        end
        n_cmp++; if (bus.data_out !== wd(24'hFACADE, 24'hBEEF01)) begin n_err++;
            $display("FAIL full_last: got %h want %h", bus.data_out,
                     wd(24'hFACADE, 24'hBEEF01)); end
        pop();
        n_cmp++; if (bus.data_ready !== 1'b0) begin n_err++;
            $display("FAIL full_empty: got %b want 0", bus.data_ready); end
    endtask

    task automatic test_drain();
        for (int i = 0; i < 9; i++) push(24'h500000 + 24'(i), 24'h600000 + 24'(i));
        bus.recording = 1'b0;
        step();
        bus.recording = 1'b1;
        step();
        // DRAIN -> CAPTURE keeps both contents and the overflow flag.
        n_cmp++; if (bus.overflow !== 1'b1 || bus.fill_level !== 4'd8) begin n_err++;
            $display("FAIL drain_resume: got ovf=%b fill=%0d want 1/8", bus.overflow,
                     bus.fill_level); end
        for (int i = 0; i < 5; i++) pop();
        bus.recording = 1'b0;
        push(24'h0BAD00, 24'h0BAD00);
        n_cmp++; if (bus.fill_level !== 4'd3) begin n_err++;
            $display("FAIL drain_edge_wr: got %0d want 3", bus.fill_level); end
        for (int k = 0; k < 3; k++) begin
            n_cmp++;
            if (bus.data_out !== wd(24'h500005 + 24'(k), 24'h600005 + 24'(k))) begin n_err++;
                $display("FAIL drain_order[%0d]: got %h want %h", k, bus.data_out,
                         wd(24'h500005 + 24'(k), 24'h600005 + 24'(k))); end
            bus.get_data = 1'b1;
            push(24'h0BAD01, 24'h0BAD01);
            bus.get_data = 1'b0;
            n_cmp++; if (bus.fill_level !== 4'(2 - k)) begin n_err++;
                $display("FAIL drain_fill[%0d]: got %0d want %0d", k, bus.fill_level, 2 - k); end
        end
        step();
        bus.recording = 1'b1;
        step();
        // Only the IDLE -> CAPTURE path clears overflow.
        n_cmp++; if (bus.overflow !== 1'b0) begin n_err++;
            $display("FAIL drain_idle: got ovf=%b want 0", bus.overflow); end
        n_cmp++; if (bus.data_out !== wd(24'h500007, 24'h600007)) begin n_err++;
            $display("FAIL drain_hold: got %h want %h", bus.data_out,
                     wd(24'h500007, 24'h600007)); end
    endtask

    task automatic test_empty_wrap();
        pop();
        n_cmp++; if (bus.fill_level !== 4'd0 || bus.data_ready !== 1'b0 ||
                     bus.data_out !== wd(24'h500007, 24'h600007)) begin n_err++;
            $display("FAIL empty_pop: got fill=%0d ready=%b data=%h", bus.fill_level,
                     bus.data_ready, bus.data_out); end
        bus.get_data = 1'b1;
        push(24'h700000, 24'h800000);
        n_cmp++; if (bus.fill_level !== 4'd1 || bus.data_out !== wd(24'h700000, 24'h800000))
        begin n_err++;
            $display("FAIL empty_wr_pop: got fill=%0d data=%h", bus.fill_level, bus.data_out); end
        for (int j = 1; j <= 20; j++) begin
            push(24'h700000 + 24'(j), 24'h800000 + 24'(j));
            n_cmp++;
            if (bus.data_out !== wd(24'h700000 + 24'(j), 24'h800000 + 24'(j)) ||
                bus.fill_level !== 4'd1 || bus.data_ready !== 1'b1) begin n_err++;
                $display("FAIL wrap[%0d]: got data=%h fill=%0d ready=%b", j, bus.data_out,
                         bus.fill_level, bus.data_ready); end
        end
        step();
        bus.get_data = 1'b0;
        n_cmp++; if (bus.fill_level !== 4'd0 || bus.data_ready !== 1'b0) begin n_err++;
            $display("FAIL wrap_end: got fill=%0d ready=%b", bus.fill_level, bus.data_ready); end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 5; i++) push(24'h900000 + 24'(i), 24'hA00000 + 24'(i));
        n_cmp++; if (bus.fill_level !== 4'd5) begin n_err++;
            $display("FAIL rmid_pre: got %0d want 5", bus.fill_level); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (bus.fill_level !== 4'd0 || bus.data_ready !== 1'b0 ||
                     bus.data_out !== 64'h0) begin n_err++;
            $display("FAIL rmid_async: got fill=%0d ready=%b data=%h", bus.fill_level,
                     bus.data_ready, bus.data_out); end
        #2 rst = 1'b0;
        // State is IDLE: this strobe is ignored while the FSM enters CAPTURE.
        push(24'h0BAD02, 24'h0BAD02);
        n_cmp++; if (bus.fill_level !== 4'd0) begin n_err++;
            $display("FAIL rmid_idle: got %0d want 0", bus.fill_level); end
        push(24'hC0FFEE, 24'h654321);
        n_cmp++; if (bus.fill_level !== 4'd1 || bus.data_out !== wd(24'hC0FFEE, 24'h654321))
        begin n_err++;
            $display("FAIL rmid_first: got fill=%0d data=%h", bus.fill_level, bus.data_out); end
    endtask

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample_l     = '0;
        bus.sample_r     = '0;
        bus.recording    = 1'b0;
        bus.get_data     = 1'b0;
        test_reset();
        test_basic();
        test_overflow();
        test_full_simul();
        test_drain();
        test_empty_wrap();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/sample_packer.md
SAMPLE_PACKER -- requirements
Module: sample_packer

Interface
REQ-001 Parameter DEPTH, default 8, FIFO depth in 64-bit words; SHALL be a power of two, 4..64.
REQ-002 Parameter PAD, default 16'h0000, constant placed in data_out[63:48].
REQ-003 clk  input  1  system clock; all logic on posedge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 sample_valid  input  1  one-cycle strobe, new stereo sample present.
REQ-006 sample_l  input  24  left-channel sample, valid with sample_valid.
REQ-007 sample_r  input  24  right-channel sample, valid with sample_valid.
REQ-008 recording  input  1  level, capture enable from control FSM.
REQ-009 get_data  input  1  one-cycle pop request from memory controller.
REQ-010 data_out  output  64  head word {PAD, L[23:0], R[23:0]}.
REQ-011 data_ready  output  1  head word valid (FIFO non-empty).
REQ-012 fill_level  output  log2(DEPTH)+1  words currently stored.
REQ-013 overflow  output  1  sticky, sample dropped on full FIFO.
REQ-014 ovf_count  output  16  dropped-sample count; present only with SAMPLE_PACKER_OVF_CNT_EN.

Function
REQ-015 FSM states IDLE, CAPTURE, DRAIN; reset state IDLE.
REQ-016 IDLE: sample_valid ignored; recording=1 -> CAPTURE next cycle, clears overflow (and ovf_count if compiled).
REQ-017 CAPTURE: each sample_valid with FIFO not full writes {PAD, sample_l, sample_r}; recording=0 -> DRAIN.
REQ-018 DRAIN: no writes; pops continue; fill_level=0 -> IDLE; recording=1 -> CAPTURE, contents retained, overflow not cleared.
REQ-019 Pop on get_data && data_ready; get_data on empty SHALL be ignored, no pointer change.
REQ-020 Write-to-data_ready latency: exactly 1 cycle; data_out registered, first-word-fall-through.
REQ-021 After pop, next word (if any) SHALL appear on data_out the following cycle; data_out holds last value when empty.
REQ-022 Full, write only: word dropped, overflow set next cycle, FIFO unchanged.
REQ-023 Full, simultaneous write and pop: both succeed, fill_level unchanged, no overflow.
REQ-024 Empty, simultaneous write and pop: pop ignored, write accepted, no bypass.
REQ-025 Read/write pointers log2(DEPTH)+1 bits, wrap modulo 2*DEPTH; full/empty from MSB compare.
REQ-026 fill_level = wr_ptr - rd_ptr, updated same edge as pointers, never exceeds DEPTH.
REQ-027 sample_valid in cycle of CAPTURE->DRAIN transition (recording already 0) SHALL NOT be written.

Reset
REQ-028 rst asserted: state IDLE, pointers 0, fill_level 0, data_ready 0, data_out 0, overflow 0, ovf_count 0, immediately, without clock.
REQ-029 rst mid-operation discards all stored words; first post-reset write behaves as into empty FIFO.
REQ-030 rst deassertion synchronised externally; block needs no recovery cycles.

Configuration
REQ-031 Macro SAMPLE_PACKER_OVF_CNT_EN defined: ovf_count port exists, increments per dropped sample, saturates at 16'hFFFF, cleared per REQ-016/REQ-028.
REQ-032 Macro undefined: ovf_count port and counter absent; all other behaviour identical.

Verification
REQ-033 Reset, recording=1, one strobe L=24'hABCDEF R=24'h123456 -> next cycle data_ready=1, data_out=64'h0000_ABCDEF_123456, fill_level=1.
REQ-034 DEPTH=8, 10 strobes no pops -> fill_level=8, overflow=1, ovf_count=2 (macro on), first 8 words popped in order.
REQ-035 Full FIFO, strobe and get_data same cycle -> fill_level stays 8, overflow stays 0, new word last out.
REQ-036 3 words stored, recording drops -> DRAIN; 3 pops -> IDLE after fill_level=0; strobes during DRAIN ignored.
REQ-037 get_data on empty -> no change; 20 write/pop pairs -> pointer wrap, order preserved, no false full/empty.
REQ-038 rst pulsed with fill_level=5 mid-cycle -> outputs zero asynchronously, state IDLE, next capture starts empty.
